// File: rtl/sme_dom_seq_if.sv
// Handshake bundle between the two requesters, the guard-share RNG, the masked
// AND gadget and the sme_dom_seq sequencer.
interface sme_dom_seq_if;
    logic flush;
    logic req0_valid;
    logic req1_valid;
    logic req0_ready;
    logic req1_ready;
    logic rsp0_valid;
    logic rsp1_valid;
    logic rsp0_ack;
    logic rsp1_ack;
    logic rng_req;
    logic rng_valid;
    logic and_en;
    logic and_sel;
    logic busy;

    // Environment side: requesters, RNG and flush source
    modport master (
        output flush, req0_valid, req1_valid, rsp0_ack, rsp1_ack, rng_valid,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rng_req,
               and_en, and_sel, busy
    );

    // Sequencer side
    modport slave (
        input  flush, req0_valid, req1_valid, rsp0_ack, rsp1_ack, rng_valid,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rng_req,
               and_en, and_sel, busy
    );
endinterface

// File: rtl/sme_dom_seq.sv
// Sequencer that time-shares one D-share DOM-AND gadget between two requesters,
// fetching a fresh guard-share word from the RNG for every operation.
module sme_dom_seq #(
    parameter int unsigned D   = 3,
    parameter int unsigned LAT = 1
) (
    input  logic         g_clk,
    input  logic         g_resetn,
    sme_dom_seq_if.slave bus
);

    localparam int unsigned     CNT_W    = 3;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

    if (D < 2 || D > 4 || LAT < 1 || LAT > 7) begin : g_param_check
        $error("sme_dom_seq: D must be 2..4 and LAT must be 1..7");
    end

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RNG  = 3'd1,
        EXEC = 3'd2,
        WAIT = 3'd3,
        RESP = 3'd4
    } state_e;

    logic [1:0]       rst_sync_q;
    logic             rst_n;
    state_e           state_q;
    logic             rr_q;
    logic             sel_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rng_req_q;
    logic             and_en_q;
    logic             busy_q;
    logic             rsp0_q;
    logic             rsp1_q;
    logic             grant_c;
    logic             grant_sel_c;
    logic             ack_c;

    // Asynchronous assertion, synchronised release of the internal reset
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    // rr_q holds the requester served last; a tie goes to the other one
    assign grant_c     = rst_n && (state_q == IDLE) && !bus.flush &&
                         (bus.req0_valid || bus.req1_valid);
    assign grant_sel_c = (bus.req0_valid && bus.req1_valid) ? ~rr_q : bus.req1_valid;
    assign ack_c       = sel_q ? bus.rsp1_ack : bus.rsp0_ack;

    always_ff @(posedge g_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_q      <= 1'b1;
            sel_q     <= 1'b0;
            cnt_q     <= '0;
            rng_req_q <= 1'b0;
            and_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            rsp0_q    <= 1'b0;
            rsp1_q    <= 1'b0;
        end else if (bus.flush) begin
            // Abandon without a response; pointer and select are left untouched
            state_q   <= IDLE;
            cnt_q     <= '0;
            rng_req_q <= 1'b0;
            and_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            rsp0_q    <= 1'b0;
            rsp1_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_c) begin
                        state_q   <= RNG;
                        sel_q     <= grant_sel_c;
                        rng_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                RNG: begin
                    if (bus.rng_valid) begin
                        state_q   <= EXEC;
                        rng_req_q <= 1'b0;
                        and_en_q  <= 1'b1;
                    end
                end
                EXEC: begin
                    and_en_q <= 1'b0;
                    cnt_q    <= CNT_LOAD;
                    if (LAT > 1) begin
                        state_q <= WAIT;
                    end else begin
                        state_q <= RESP;
                        rsp0_q  <= ~sel_q;
                        rsp1_q  <= sel_q;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= RESP;
                        rsp0_q  <= ~sel_q;
                        rsp1_q  <= sel_q;
                    end
                end
                RESP: begin
                    if (ack_c) begin
                        state_q <= IDLE;
                        rr_q    <= sel_q;
                        busy_q  <= 1'b0;
                        rsp0_q  <= 1'b0;
                        rsp1_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Gadget enable and RNG request must vanish within the flush cycle itself
    assign bus.req0_ready = grant_c && !grant_sel_c;
    assign bus.req1_ready = grant_c && grant_sel_c;
    assign bus.rng_req    = rng_req_q && !bus.flush;
    assign bus.and_en     = and_en_q && !bus.flush;
    assign bus.and_sel    = sel_q;
    assign bus.busy       = busy_q;
    assign bus.rsp0_valid = rsp0_q;
    assign bus.rsp1_valid = rsp1_q;

endmodule

// File: tb/tb_sme_dom_seq.sv
// Scoreboard bench for sme_dom_seq: one instance with LAT=1 and one with LAT=4.
module tb_sme_dom_seq;

    logic g_clk;
    logic g_resetn;

    sme_dom_seq_if i1 ();
    sme_dom_seq_if i4 ();

    sme_dom_seq #(.D(3), .LAT(1)) u_dut1 (.g_clk(g_clk), .g_resetn(g_resetn), .bus(i1));
    sme_dom_seq #(.D(3), .LAT(4)) u_dut4 (.g_clk(g_clk), .g_resetn(g_resetn), .bus(i4));

    int   checks = 0;
    int   errors = 0;
    logic exp1_q[$];
    logic exp4_q[$];
    logic rr1;
    logic rr4;

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic cyc;
        @(posedge g_clk);
        #1;
    endtask

    task automatic smp;
        @(negedge g_clk);
    endtask

    task automatic clear_inputs;
        i1.flush = 0; i1.req0_valid = 0; i1.req1_valid = 0; i1.rsp0_ack = 0; i1.rsp1_ack = 0; i1.rng_valid = 0;
        i4.flush = 0; i4.req0_valid = 0; i4.req1_valid = 0; i4.rsp0_ack = 0; i4.rsp1_ack = 0; i4.rng_valid = 0;
    endtask

    task automatic test_reset;
        clear_inputs();
        g_resetn = 1'b0;
        i1.req0_valid = 1; i1.req1_valid = 1; i4.req0_valid = 1;
        repeat (2) cyc();
        smp();
        checks++;
        if ({i1.req0_ready, i1.req1_ready, i1.rsp0_valid, i1.rsp1_valid, i1.rng_req,
             i1.and_en, i1.busy, i1.and_sel} !== 8'b0) begin
            errors++;
            $display("FAIL reset_outs_lat1 got %b required 00000000",
                     {i1.req0_ready, i1.req1_ready, i1.rsp0_valid, i1.rsp1_valid, i1.rng_req,
                      i1.and_en, i1.busy, i1.and_sel});
        end
        checks++;
        if ({i4.req0_ready, i4.rng_req, i4.and_en, i4.busy, i4.and_sel} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outs_lat4 got %b required 00000",
                     {i4.req0_ready, i4.rng_req, i4.and_en, i4.busy, i4.and_sel});
        end
        cyc();
        clear_inputs();
        g_resetn = 1'b1;
        repeat (3) cyc();
        smp();
        checks++;
        if ({i1.busy, i4.busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release_idle got busy %b required 00", {i1.busy, i4.busy});
        end
        rr1 = 1'b1;
        rr4 = 1'b1;
    endtask

    // Both requesters valid, acks always high: grants alternate from requester 0
    task automatic test_arbitration;
        int   grants;
        int   resps;
        int   n;
        logic exp;
        grants = 0; resps = 0; n = 0;
        cyc();
        i1.req0_valid = 1; i1.req1_valid = 1; i1.rng_valid = 1; i1.rsp0_ack = 1; i1.rsp1_ack = 1;
        while (resps < 4 && n < 80) begin
            smp();
            if (i1.req0_ready || i1.req1_ready) begin
                exp = ~rr1;
                checks++;
                if ({i1.req1_ready, i1.req0_ready} !== (exp ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL arb_grant got ready %b required %b",
                             {i1.req1_ready, i1.req0_ready}, (exp ? 2'b10 : 2'b01));
                end
                exp1_q.push_back(exp);
                grants++;
            end
            if (i1.rsp0_valid || i1.rsp1_valid) begin
                checks++;
                if (exp1_q.size() == 0) begin
                    errors++;
                    $display("FAIL arb_spurious_rsp got rsp %b required none",
                             {i1.rsp1_valid, i1.rsp0_valid});
                end else begin
                    exp = exp1_q.pop_front();
                    if ({i1.rsp1_valid, i1.rsp0_valid, i1.and_sel} !== {exp, ~exp, exp}) begin
                        errors++;
                        $display("FAIL arb_rsp got rsp/sel %b required %b",
                                 {i1.rsp1_valid, i1.rsp0_valid, i1.and_sel}, {exp, ~exp, exp});
                    end
                    rr1 = exp;
                    resps++;
                end
            end
            cyc();
            n++;
            if (resps == 4) begin
                i1.req0_valid = 0; i1.req1_valid = 0; i1.rsp0_ack = 0; i1.rsp1_ack = 0;
            end
        end
        checks++;
        if (resps != 4 || grants != 4) begin
            errors++;
            $display("FAIL arb_count got grants %0d resps %0d required 4 and 4", grants, resps);
        end
        clear_inputs();
    endtask

    // Single request on LAT=1 with cycle-exact outputs; stray acks must be ignored
    task automatic test_single;
        logic exp;
        cyc(); i1.req0_valid = 1; i1.rng_valid = 1;
        smp();
        checks++;
        if ({i1.req1_ready, i1.req0_ready} !== 2'b01) begin
            errors++; $display("FAIL single_c0_ready got %b required 01", {i1.req1_ready, i1.req0_ready});
        end
        exp1_q.push_back(1'b0);
        cyc(); i1.req0_valid = 0; i1.rsp0_ack = 1;
        smp();
        checks++;
        if ({i1.rng_req, i1.and_en, i1.and_sel, i1.busy} !== 4'b1001) begin
            errors++; $display("FAIL single_c1 got rng/en/sel/busy %b required 1001",
                               {i1.rng_req, i1.and_en, i1.and_sel, i1.busy});
        end
        cyc();
        smp();
        checks++;
        if ({i1.rng_req, i1.and_en} !== 2'b01) begin
            errors++; $display("FAIL single_c2 got rng/en %b required 01", {i1.rng_req, i1.and_en});
        end
        cyc(); i1.rsp0_ack = 0; i1.rsp1_ack = 1;
        smp();
        exp = exp1_q.pop_front();
        checks++;
        if ({i1.rsp1_valid, i1.rsp0_valid, i1.and_en} !== {exp, ~exp, 1'b0}) begin
            errors++; $display("FAIL single_c3_rsp got %b required %b",
                               {i1.rsp1_valid, i1.rsp0_valid, i1.and_en}, {exp, ~exp, 1'b0});
        end
        cyc(); i1.rsp1_ack = 0;
        smp();
        checks++;
        if (i1.rsp0_valid !== 1'b1) begin
            errors++; $display("FAIL single_c4_hold got rsp0 %b required 1", i1.rsp0_valid);
        end
        cyc(); i1.rsp0_ack = 1;
        smp();
        cyc(); i1.rsp0_ack = 0;
        smp();
        checks++;
        if ({i1.busy, i1.rsp0_valid, i1.rsp1_valid} !== 3'b000) begin
            errors++; $display("FAIL single_c6_idle got busy/rsp %b required 000",
                               {i1.busy, i1.rsp0_valid, i1.rsp1_valid});
        end
        rr1 = 1'b0;
        clear_inputs();
    endtask

    // RNG withheld for 10 cycles: request stays up, gadget is not started
    task automatic test_rng_stall;
        int   bad;
        logic exp;
        bad = 0;
        cyc(); i1.req1_valid = 1;
        smp();
        checks++;
        if ({i1.req1_ready, i1.req0_ready} !== 2'b10) begin
            errors++; $display("FAIL stall_grant got %b required 10", {i1.req1_ready, i1.req0_ready});
        end
        exp1_q.push_back(1'b1);
        cyc(); i1.req1_valid = 0;
        for (int k = 0; k < 10; k++) begin
            smp();
            if ({i1.rng_req, i1.and_en} !== 2'b10) bad++;
            cyc();
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL stall_hold got %0d bad cycles required 0", bad);
        end
        i1.rng_valid = 1;
        smp();
        cyc(); i1.rng_valid = 0;
        smp();
        checks++;
        if ({i1.rng_req, i1.and_en} !== 2'b01) begin
            errors++; $display("FAIL stall_en_pulse got rng/en %b required 01", {i1.rng_req, i1.and_en});
        end
        cyc();
        smp();
        exp = exp1_q.pop_front();
        checks++;
        if ({i1.and_en, i1.rsp1_valid, i1.rsp0_valid} !== {1'b0, exp, ~exp}) begin
            errors++; $display("FAIL stall_rsp got en/rsp %b required %b",
                               {i1.and_en, i1.rsp1_valid, i1.rsp0_valid}, {1'b0, exp, ~exp});
        end
        cyc(); i1.rsp1_ack = 1;
        smp();
        cyc(); i1.rsp1_ack = 0;
        smp();
        checks++;
        if (i1.busy !== 1'b0) begin
            errors++; $display("FAIL stall_idle got busy %b required 0", i1.busy);
        end
        rr1 = 1'b1;
        clear_inputs();
    endtask

    // LAT=4: three WAIT cycles between the enable pulse and the response
    task automatic test_lat4;
        int   t;
        int   t_en;
        int   t_rsp;
        int   waits;
        logic exp;
        t = 0; t_en = -1; t_rsp = -1; waits = 0;
        cyc(); i4.req0_valid = 1; i4.rng_valid = 1;
        smp();
        checks++;
        if ({i4.req1_ready, i4.req0_ready} !== 2'b01) begin
            errors++; $display("FAIL lat4_grant got %b required 01", {i4.req1_ready, i4.req0_ready});
        end
        exp4_q.push_back(1'b0);
        cyc(); i4.req0_valid = 0;
        while (t_rsp < 0 && t < 30) begin
            smp();
            if (i4.and_en) t_en = t;
            else if (t_en >= 0 && i4.busy && !i4.rng_req && !i4.rsp0_valid && !i4.rsp1_valid) waits++;
            if (i4.rsp0_valid || i4.rsp1_valid) begin
                t_rsp = t;
                exp = exp4_q.pop_front();
                checks++;
                if ({i4.rsp1_valid, i4.rsp0_valid} !== {exp, ~exp}) begin
                    errors++; $display("FAIL lat4_rsp got %b required %b",
                                       {i4.rsp1_valid, i4.rsp0_valid}, {exp, ~exp});
                end
            end else begin
                cyc();
            end
            t++;
        end
        checks++;
        if (t_rsp < 0 || t_en < 0 || (t_rsp - t_en) != 4 || waits != 3) begin
            errors++; $display("FAIL lat4_timing got en %0d rsp %0d waits %0d required rsp-en 4 waits 3",
                               t_en, t_rsp, waits);
        end
        cyc(); i4.rsp0_ack = 1;
        smp();
        cyc(); i4.rsp0_ack = 0;
        smp();
        checks++;
        if (i4.busy !== 1'b0) begin
            errors++; $display("FAIL lat4_idle got busy %b required 0", i4.busy);
        end
        rr4 = 1'b0;
        exp4_q.delete();
        clear_inputs();
    endtask

    // Flush in RNG (with rng_valid) and in RESP on LAT=1; pointer must not move
    task automatic test_flush_lat1;
        logic exp;
        exp = ~rr1;
        cyc(); i1.req0_valid = 1; i1.req1_valid = 1;
        smp();
        checks++;
        if ({i1.req1_ready, i1.req0_ready} !== (exp ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL flush_grant got %b required %b",
                               {i1.req1_ready, i1.req0_ready}, (exp ? 2'b10 : 2'b01));
        end
        exp1_q.push_back(exp);
        cyc(); i1.req0_valid = 0; i1.req1_valid = 0;
        smp();
        cyc(); i1.flush = 1; i1.rng_valid = 1;
        smp();
        checks++;
        if ({i1.rng_req, i1.and_en} !== 2'b00) begin
            errors++; $display("FAIL flush_rng_comb got rng/en %b required 00", {i1.rng_req, i1.and_en});
        end
        void'(exp1_q.pop_front());
        cyc(); i1.flush = 0; i1.rng_valid = 0;
        smp();
        checks++;
        if ({i1.busy, i1.and_en, i1.rsp0_valid, i1.rsp1_valid} !== 4'b0000) begin
            errors++; $display("FAIL flush_rng_idle got %b required 0000",
                               {i1.busy, i1.and_en, i1.rsp0_valid, i1.rsp1_valid});
        end
        cyc(); i1.req0_valid = 1; i1.req1_valid = 1; i1.rng_valid = 1;
        smp();
        checks++;
        if ({i1.req1_ready, i1.req0_ready} !== (exp ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL flush_regrant1 got %b required %b",
                               {i1.req1_ready, i1.req0_ready}, (exp ? 2'b10 : 2'b01));
        end
        exp1_q.push_back(exp);
        cyc(); i1.req0_valid = 0; i1.req1_valid = 0;
        smp(); cyc(); smp(); cyc();
        smp();
        checks++;
        if ({i1.rsp1_valid, i1.rsp0_valid} !== {exp, ~exp}) begin
            errors++; $display("FAIL flush_pre_resp got %b required %b",
                               {i1.rsp1_valid, i1.rsp0_valid}, {exp, ~exp});
        end
        void'(exp1_q.pop_front());
        cyc(); i1.flush = 1;
        smp();
        cyc(); i1.flush = 0;
        smp();
        checks++;
        if ({i1.busy, i1.rsp0_valid, i1.rsp1_valid} !== 3'b000) begin
            errors++; $display("FAIL flush_resp_idle got %b required 000",
                               {i1.busy, i1.rsp0_valid, i1.rsp1_valid});
        end
        cyc(); i1.req0_valid = 1; i1.req1_valid = 1;
        smp();
        checks++;
        if ({i1.req1_ready, i1.req0_ready} !== (exp ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL flush_regrant2 got %b required %b",
                               {i1.req1_ready, i1.req0_ready}, (exp ? 2'b10 : 2'b01));
        end
        exp1_q.push_back(exp);
        cyc(); i1.req0_valid = 0; i1.req1_valid = 0;
        smp(); cyc(); smp(); cyc(); i1.rsp0_ack = 1; i1.rsp1_ack = 1;
        smp();
        checks++;
        if (exp1_q.size() == 0) begin
            errors++; $display("FAIL flush_final_rsp got empty scoreboard required one entry");
        end else begin
            exp = exp1_q.pop_front();
            if ({i1.rsp1_valid, i1.rsp0_valid} !== {exp, ~exp}) begin
                errors++; $display("FAIL flush_final_rsp got %b required %b",
                                   {i1.rsp1_valid, i1.rsp0_valid}, {exp, ~exp});
            end
            rr1 = exp;
        end
        cyc(); i1.rsp0_ack = 0; i1.rsp1_ack = 0;
        smp();
        clear_inputs();
    endtask

    // Flush in EXEC and in WAIT on LAT=4
    task automatic test_flush_lat4;
        logic exp;
        int   bad;
        exp = ~rr4;
        bad = 0;
        cyc(); i4.req0_valid = 1; i4.req1_valid = 1; i4.rng_valid = 1;
        smp();
        checks++;
        if ({i4.req1_ready, i4.req0_ready} !== (exp ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL flush4_grant got %b required %b",
                               {i4.req1_ready, i4.req0_ready}, (exp ? 2'b10 : 2'b01));
        end
        cyc(); i4.req0_valid = 0; i4.req1_valid = 0;
        smp();
        cyc(); i4.flush = 1;
        smp();
        checks++;
        if ({i4.and_en, i4.busy} !== 2'b01) begin
            errors++; $display("FAIL flush_exec_comb got en/busy %b required 01", {i4.and_en, i4.busy});
        end
        cyc(); i4.flush = 0;
        smp();
        checks++;
        if (i4.busy !== 1'b0) begin
            errors++; $display("FAIL flush_exec_idle got busy %b required 0", i4.busy);
        end
        cyc(); i4.req0_valid = 1; i4.req1_valid = 1;
        smp();
        checks++;
        if ({i4.req1_ready, i4.req0_ready} !== (exp ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL flush_exec_regrant got %b required %b",
                               {i4.req1_ready, i4.req0_ready}, (exp ? 2'b10 : 2'b01));
        end
        cyc(); i4.req0_valid = 0; i4.req1_valid = 0;
        smp(); cyc(); smp(); cyc();
        smp();
        checks++;
        if ({i4.busy, i4.and_en, i4.rng_req, i4.rsp0_valid, i4.rsp1_valid} !== 5'b10000) begin
            errors++; $display("FAIL flush4_in_wait got %b required 10000",
                               {i4.busy, i4.and_en, i4.rng_req, i4.rsp0_valid, i4.rsp1_valid});
        end
        cyc(); i4.flush = 1;
        smp();
        cyc(); i4.flush = 0;
        for (int k = 0; k < 5; k++) begin
            smp();
            if ({i4.busy, i4.rsp0_valid, i4.rsp1_valid} !== 3'b000) bad++;
            cyc();
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL flush_wait_idle got %0d bad cycles required 0", bad);
        end
        i4.req0_valid = 1; i4.req1_valid = 1;
        smp();
        checks++;
        if ({i4.req1_ready, i4.req0_ready} !== (exp ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL flush_wait_regrant got %b required %b",
                               {i4.req1_ready, i4.req0_ready}, (exp ? 2'b10 : 2'b01));
        end
        cyc(); i4.req0_valid = 0; i4.req1_valid = 0; i4.flush = 1;
        cyc(); i4.flush = 0;
        clear_inputs();
    endtask

    // Asynchronous reset in EXEC, then a clean grant after release
    task automatic test_async_reset;
        logic exp;
        cyc(); i1.req1_valid = 1; i1.rng_valid = 1;
        smp();
        cyc(); i1.req1_valid = 0;
        smp(); cyc();
        smp();
        checks++;
        if ({i1.and_en, i1.and_sel, i1.busy} !== 3'b111) begin
            errors++; $display("FAIL areset_pre got en/sel/busy %b required 111",
                               {i1.and_en, i1.and_sel, i1.busy});
        end
        #1 g_resetn = 1'b0;
        #1;
        checks++;
        if ({i1.and_en, i1.busy, i1.rng_req, i1.and_sel, i1.rsp0_valid, i1.rsp1_valid} !== 6'b0) begin
            errors++; $display("FAIL areset_drop got %b required 000000",
                               {i1.and_en, i1.busy, i1.rng_req, i1.and_sel, i1.rsp0_valid, i1.rsp1_valid});
        end
        rr1 = 1'b1;
        rr4 = 1'b1;
        exp1_q.delete();
        clear_inputs();
        repeat (2) cyc();
        g_resetn = 1'b1;
        repeat (3) cyc();
        i1.req0_valid = 1; i1.req1_valid = 1; i1.rng_valid = 1;
        smp();
        exp = ~rr1;
        checks++;
        if ({i1.req1_ready, i1.req0_ready} !== (exp ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL areset_regrant got %b required %b",
                               {i1.req1_ready, i1.req0_ready}, (exp ? 2'b10 : 2'b01));
        end
        exp1_q.push_back(exp);
        cyc(); i1.req0_valid = 0; i1.req1_valid = 0;
        smp(); cyc(); smp(); cyc(); i1.rsp0_ack = 1; i1.rsp1_ack = 1;
        smp();
        exp = exp1_q.pop_front();
        checks++;
        if ({i1.rsp1_valid, i1.rsp0_valid} !== {exp, ~exp}) begin
            errors++; $display("FAIL areset_rsp got %b required %b",
                               {i1.rsp1_valid, i1.rsp0_valid}, {exp, ~exp});
        end
        cyc(); i1.rsp0_ack = 0; i1.rsp1_ack = 0;
        smp();
        checks++;
        if (i1.busy !== 1'b0) begin
            errors++; $display("FAIL areset_idle got busy %b required 0", i1.busy);
        end
        rr1 = exp;
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_single();
        test_rng_stall();
        test_lat4();
        test_flush_lat1();
        test_flush_lat4();
        test_async_reset();
        repeat (2) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
